md_unit: RTL and testbench

- Parametrised multi-cycle multiply/divide unit with HI/LO registers, for the pipelined core that supersedes the single-cycle datapath.
- Sits beside the ALU in the execute stage.
- Accepts one operation at a time via a start/busy handshake.
- Results appear in HI/LO after a configurable latency.

---
 rtl/md_unit.sv | 100 ++++++++++
 tb/tb_md_unit.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit with HI/LO registers.
// Define MD_UNIT_MADD_EN to enable MADD/MADDU (ops 6/7); otherwise they are no-ops.
module md_unit #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10,
  parameter int CNT_W      = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2*WIDTH-1:0] res_q, res_d, wb;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic dz_q, dz_d, done_q, done_d;
  logic sg, is_div, valid, accept;
  logic [2*WIDTH-1:0] xa, xb, prod;
  logic [WIDTH-1:0] ma, mb, den, uq, ur, q, r;
  assign sg     = ~op[0];
  assign is_div = op[2:1] == 2'b01;
  assign xa     = {{WIDTH{sg & a[WIDTH-1]}}, a};
  assign xb     = {{WIDTH{sg & b[WIDTH-1]}}, b};
  assign prod   = xa * xb;
  // Magnitude divide, then restore signs: quotient truncates toward zero, remainder follows dividend.
  assign ma  = (sg && a[WIDTH-1]) ? -a : a;
  assign mb  = (sg && b[WIDTH-1]) ? -b : b;
  assign den = (b == '0) ? WIDTH'(1) : mb;
  assign uq  = ma / den;
  assign ur  = ma % den;
  assign q   = (sg && (a[WIDTH-1] ^ b[WIDTH-1])) ? -uq : uq;
  assign r   = (sg && a[WIDTH-1]) ? -ur : ur;
  assign accept = state_q == IDLE && start && valid;
`ifdef MD_UNIT_MADD_EN
  logic mac_q, mac_d;
  assign valid = !op[2] || op[1];
  assign wb    = mac_q ? {hi_q, lo_q} + res_q : res_q;
  always_comb mac_d = accept ? op[2] : mac_q;
  always_ff @(posedge clk or negedge reset)
    if (!reset) mac_q <= 1'b0;
    else mac_q <= mac_d;
`else
  assign valid = !op[2];
  assign wb    = res_q;
`endif
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    dz_d    = dz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    if (state_q == IDLE) begin
      if (accept) begin
        state_d = RUN;
        cnt_d   = is_div ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MUL_CYCLES - 1);
        res_d   = is_div ? {r, q} : prod;
        dz_d    = is_div && b == '0;
      end else if (start && op == 3'd4) hi_d = a;
      else if (start && op == 3'd5) lo_d = a;
    end else if (cnt_q == '0) begin
      state_d = IDLE;
      done_d  = 1'b1;
      {hi_d, lo_d} = dz_q ? {hi_q, lo_q} : wb;
    end else cnt_d = cnt_q - 1'b1;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      res_q   <= '0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      dz_q    <= dz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end
  assign busy = state_q == RUN;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;
endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed self-checking bench for md_unit with hand-computed HI/LO results.
module tb_md_unit;
  logic        clk, reset, start, busy, done;
  logic [2:0]  op;
  logic [31:0] a, b, hi, lo;
  int checks = 0;
  int errors = 0;
  int n;
  logic seen;

  md_unit dut (.clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
               .busy(busy), .done(done), .hi(hi), .lo(lo));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1;
    op = o;
    a = x;
    b = y;
    tick;
    start = 1'b0;
    a = 32'h5A5A5A5A;
    b = 32'hA5A5A5A5;
  endtask

  task automatic wait_idle(output int cnt);
    cnt = 0;
    while (busy && cnt < 50) begin
      cnt++;
      tick;
    end
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    op = 3'd0;
    a = '0;
    b = '0;
    tick;
    tick;
    reset = 1'b1;
    chk("reset_hi", hi, 0);
    chk("reset_lo", lo, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);

    issue(3'd0, 32'hFFFFFFFE, 32'd3);
    wait_idle(n);
    chk("mult_busy_cycles", n, 5);
    chk("mult_done", done, 1);
    chk("mult_hi", hi, 32'hFFFFFFFF);
    chk("mult_lo", lo, 32'hFFFFFFFA);
    tick;
    chk("mult_done_one_cycle", done, 0);

    issue(3'd2, 32'hFFFFFFF9, 32'd2);
    wait_idle(n);
    chk("div_busy_cycles", n, 10);
    chk("div_lo", lo, 32'hFFFFFFFD);
    chk("div_hi", hi, 32'hFFFFFFFF);
    chk("div_done", done, 1);
    issue(3'd3, 32'hFFFFFFF9, 32'd2);
    chk("b2b_accept_busy", busy, 1);
    wait_idle(n);
    chk("divu_busy_cycles", n, 10);
    chk("divu_lo", lo, 32'h7FFFFFFC);
    chk("divu_hi", hi, 32'h00000001);

    issue(3'd2, 32'h80000000, 32'hFFFFFFFF);
    wait_idle(n);
    chk("divovf_lo", lo, 32'h80000000);
    chk("divovf_hi", hi, 32'h00000000);

    issue(3'd5, 32'h7FFFFFFC, 32'd0);
    issue(3'd4, 32'h12345678, 32'd0);
    chk("mthi_hi", hi, 32'h12345678);
    chk("mthi_busy", busy, 0);
    chk("mthi_lo_kept", lo, 32'h7FFFFFFC);
    tick;
    chk("mthi_no_done", done, 0);
    issue(3'd3, 32'd99, 32'd0);
    wait_idle(n);
    chk("div0_busy_cycles", n, 10);
    chk("div0_done", done, 1);
    chk("div0_hi", hi, 32'h12345678);
    chk("div0_lo", lo, 32'h7FFFFFFC);

    issue(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    issue(3'd5, 32'h0000AAAA, 32'd0);
    chk("mtlo_ignored_busy", lo, 32'h7FFFFFFC);
    issue(3'd0, 32'd2, 32'd2);
    wait_idle(n);
    chk("multu_remaining_busy", n, 3);
    chk("multu_hi", hi, 32'hFFFFFFFE);
    chk("multu_lo", lo, 32'h00000001);
    tick;
    chk("ignored_mult_no_busy", busy, 0);

    issue(3'd4, 32'h00000000, 32'd0);
    issue(3'd5, 32'hFFFFFFFF, 32'd0);
    issue(3'd7, 32'd1, 32'd1);
`ifdef MD_UNIT_MADD_EN
    chk("maddu_busy", busy, 1);
    wait_idle(n);
    chk("maddu_busy_cycles", n, 5);
    chk("maddu_hi", hi, 32'h00000001);
    chk("maddu_lo", lo, 32'h00000000);
`else
    chk("maddu_off_busy", busy, 0);
    tick;
    chk("maddu_off_done", done, 0);
    chk("maddu_off_hi", hi, 32'h00000000);
    chk("maddu_off_lo", lo, 32'hFFFFFFFF);
`endif

    issue(3'd0, 32'd100, 32'd7);
    issue(3'd2, 32'd100, 32'd7);
    tick;
    reset = 1'b0;
    #1;
    chk("abort_hi", hi, 0);
    chk("abort_lo", lo, 0);
    chk("abort_busy", busy, 0);
    tick;
    tick;
    reset = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick;
      seen = seen | done | busy;
    end
    chk("abort_no_activity", seen, 0);
    chk("abort_hi_kept", hi, 0);
    chk("abort_lo_kept", lo, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
